// File: rtl/riscv_timer_multi.sv
// Multi-channel bus timer: shared prescaler, per-channel compare/reload, W1C irq.
// Optional capture inputs and CAPTURE registers under `TIMER_CAPTURE_EN.
module riscv_timer_multi #(
    parameter int NUM_CH     = 4,
    parameter int CNT_W      = 32,
    parameter int PRESCALE_W = 16,
    parameter int ADDR_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic [NUM_CH-1:0] irq_vec,
    output logic              irq
`ifdef TIMER_CAPTURE_EN
    ,
    input  logic [NUM_CH-1:0] capture_in
`endif
);
    localparam int BLK_W = ADDR_W - 4;

    logic [BLK_W-1:0]  blk;
    logic [1:0]        rsel;
    logic              wr, rd, g_hit, tick;
    logic [NUM_CH-1:0] ch_hit;
    logic              unused_addr;

    logic                  gen_q, gen_d;
    logic [PRESCALE_W-1:0] pre_q, pre_d, pcnt_q, pcnt_d;
    logic [NUM_CH-1:0]     stat_q, stat_d, ien_q, ien_d;
    logic [NUM_CH-1:0]     cen_q, cen_d, car_q, car_d;
    logic [CNT_W-1:0]      cnt_q [NUM_CH];
    logic [CNT_W-1:0]      cnt_d [NUM_CH];
    logic [CNT_W-1:0]      cmp_q [NUM_CH];
    logic [CNT_W-1:0]      cmp_d [NUM_CH];
    logic [CNT_W-1:0]      rld_q [NUM_CH];
    logic [CNT_W-1:0]      rld_d [NUM_CH];
    logic [31:0]           rdata_q, rdata_d;

    assign blk         = addr[ADDR_W-1:4];
    assign rsel        = addr[3:2];
    assign unused_addr = ^addr[1:0];
    assign wr          = sel & we;
    assign rd          = sel & ~we;
    assign g_hit       = (blk == '0);
    assign tick        = gen_q && (pcnt_q == pre_q);

    always_comb begin
        for (int n = 0; n < NUM_CH; n++) begin
            ch_hit[n] = (blk == BLK_W'(4 + n));
        end
    end

`ifdef TIMER_CAPTURE_EN
    logic [NUM_CH-1:0] sync1_q, sync2_q, sprev_q;
    logic [CNT_W-1:0]  cap_q [NUM_CH];
    logic [CNT_W-1:0]  cap_d [NUM_CH];

    always_comb begin
        for (int n = 0; n < NUM_CH; n++) begin
            cap_d[n] = cap_q[n];
            if (sync2_q[n] && !sprev_q[n]) begin
                cap_d[n] = cnt_q[n];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sprev_q <= '0;
            for (int n = 0; n < NUM_CH; n++) cap_q[n] <= '0;
        end else begin
            sync1_q <= capture_in;
            sync2_q <= sync1_q;
            sprev_q <= sync2_q;
            for (int n = 0; n < NUM_CH; n++) cap_q[n] <= cap_d[n];
        end
    end
`endif

    always_comb begin
        gen_d  = gen_q;
        pre_d  = pre_q;
        stat_d = stat_q;
        ien_d  = ien_q;
        cen_d  = cen_q;
        car_d  = car_q;
        for (int n = 0; n < NUM_CH; n++) begin
            cnt_d[n] = cnt_q[n];
            cmp_d[n] = cmp_q[n];
            rld_d[n] = rld_q[n];
        end
        pcnt_d = (!gen_q || tick) ? '0 : pcnt_q + 1'b1;

        if (wr && g_hit) begin
            unique case (rsel)
                2'd0: gen_d = wdata[0];
                2'd1: begin
                    pre_d  = wdata[PRESCALE_W-1:0];
                    pcnt_d = '0;
                end
                2'd2: stat_d = stat_q & ~wdata[NUM_CH-1:0];
                2'd3: ien_d = wdata[NUM_CH-1:0];
            endcase
        end

        // Status sets land after the W1C above so a same-cycle set wins.
        for (int n = 0; n < NUM_CH; n++) begin
            if (tick && cen_q[n] && !(wr && ch_hit[n] && !rsel[0])) begin
                if (cnt_q[n] == cmp_q[n]) begin
                    stat_d[n] = 1'b1;
                    if (car_q[n]) cnt_d[n] = rld_q[n];
                    else          cen_d[n] = 1'b0;
                end else begin
                    cnt_d[n] = cnt_q[n] + 1'b1;
                end
            end
            if (wr && ch_hit[n]) begin
                unique case (rsel)
                    2'd0: cnt_d[n] = wdata[CNT_W-1:0];
                    2'd1: cmp_d[n] = wdata[CNT_W-1:0];
                    2'd2: begin
                        cen_d[n] = wdata[0];
                        car_d[n] = wdata[1];
                    end
                    2'd3: rld_d[n] = wdata[CNT_W-1:0];
                endcase
            end
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (rd) begin
            rdata_d = '0;
            if (g_hit) begin
                unique case (rsel)
                    2'd0: rdata_d = {31'b0, gen_q};
                    2'd1: rdata_d = 32'(pre_q);
                    2'd2: rdata_d = 32'(stat_q);
                    2'd3: rdata_d = 32'(ien_q);
                endcase
            end
            for (int n = 0; n < NUM_CH; n++) begin
                if (ch_hit[n]) begin
                    unique case (rsel)
                        2'd0: rdata_d = 32'(cnt_q[n]);
                        2'd1: rdata_d = 32'(cmp_q[n]);
                        2'd2: rdata_d = {30'b0, car_q[n], cen_q[n]};
                        2'd3: rdata_d = 32'(rld_q[n]);
                    endcase
                end
`ifdef TIMER_CAPTURE_EN
                if (blk[BLK_W-1:1] == (BLK_W-1)'(1) && {blk[0], rsel} == 3'(n)) begin
                    rdata_d = 32'(cap_q[n]);
                end
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gen_q   <= 1'b0;
            pre_q   <= '0;
            pcnt_q  <= '0;
            stat_q  <= '0;
            ien_q   <= '0;
            cen_q   <= '0;
            car_q   <= '0;
            rdata_q <= '0;
            for (int n = 0; n < NUM_CH; n++) begin
                cnt_q[n] <= '0;
                cmp_q[n] <= '0;
                rld_q[n] <= '0;
            end
        end else begin
            gen_q   <= gen_d;
            pre_q   <= pre_d;
            pcnt_q  <= pcnt_d;
            stat_q  <= stat_d;
            ien_q   <= ien_d;
            cen_q   <= cen_d;
            car_q   <= car_d;
            rdata_q <= rdata_d;
            for (int n = 0; n < NUM_CH; n++) begin
                cnt_q[n] <= cnt_d[n];
                cmp_q[n] <= cmp_d[n];
                rld_q[n] <= rld_d[n];
            end
        end
    end

    assign rdata   = rdata_q;
    assign irq_vec = stat_q & ien_q;
    assign irq     = |irq_vec;
endmodule
